// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths, the
// control FSM state encoding, access-size encoding and byte-lane masks.
package mem_stage_pkg;

  localparam int NB_DATA  = 32;  // data / address width
  localparam int NB_WADDR = 8;   // word-address width (2^NB_WADDR words)
  localparam int NB_BYTE  = 8;   // bits per byte lane
  localparam int NB_LANES = 4;   // byte lanes per word

  // Control FSM: CLEAR wipes the memory after reset, IDLE is normal use.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Access size after applying the word > halfword > byte priority.
  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  localparam logic [NB_LANES-1:0] LANES_NONE    = 4'b0000;
  localparam logic [NB_LANES-1:0] LANES_BYTE0   = 4'b0001;
  localparam logic [NB_LANES-1:0] LANES_LO_HALF = 4'b0011;
  localparam logic [NB_LANES-1:0] LANES_HI_HALF = 4'b1100;
  localparam logic [NB_LANES-1:0] LANES_ALL     = 4'b1111;

  // Collapse the three size enables into one size code.
  function automatic size_e decode_size(input logic byte_en,
                                        input logic half_en,
                                        input logic word_en);
    if (word_en)      return SZ_WORD;
    else if (half_en) return SZ_HALF;
    else if (byte_en) return SZ_BYTE;
    else              return SZ_NONE;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: word-addressed storage split into byte lanes.
// Ports:
//   i_clock              write clock
//   i_wr_en / i_wr_be    write strobe and per-lane enables
//   i_wr_addr/i_wr_data  write word address and lane-aligned data
//   i_rd_addr/o_rd_data  asynchronous load read port
//   i_dbg_addr/o_dbg_data asynchronous debug read port
module data_memory #(
  parameter int NB_DATA  = mem_stage_pkg::NB_DATA,
  parameter int NB_WADDR = mem_stage_pkg::NB_WADDR
) (
  input  logic                                i_clock,
  input  logic                                i_wr_en,
  input  logic [mem_stage_pkg::NB_LANES-1:0]  i_wr_be,
  input  logic [NB_WADDR-1:0]                 i_wr_addr,
  input  logic [NB_DATA-1:0]                  i_wr_data,
  input  logic [NB_WADDR-1:0]                 i_rd_addr,
  output logic [NB_DATA-1:0]                  o_rd_data,
  input  logic [NB_WADDR-1:0]                 i_dbg_addr,
  output logic [NB_DATA-1:0]                  o_dbg_data
);
  import mem_stage_pkg::*;

  localparam int DEPTH = 2 ** NB_WADDR;

  // One array per byte lane so partial stores never touch other lanes.
  genvar gi;
  generate
    for (gi = 0; gi < NB_LANES; gi++) begin : g_lane
      logic [NB_BYTE-1:0] lane_q [DEPTH];

      always_ff @(posedge i_clock) begin
        if (i_wr_en && i_wr_be[gi]) begin
          lane_q[i_wr_addr] <= i_wr_data[gi*NB_BYTE +: NB_BYTE];
        end
      end

      assign o_rd_data[gi*NB_BYTE +: NB_BYTE]  = lane_q[i_rd_addr];
      assign o_dbg_data[gi*NB_BYTE +: NB_BYTE] = lane_q[i_dbg_addr];
    end
  endgenerate

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Byte/halfword/word loads and stores on a
// little-endian data memory, branch decision, and a post-reset clear that
// zeroes every word before the stage reports ready.
// Ports:
//   i_clock, i_reset (sync, active-high), i_pipeline_enable (0 = freeze)
//   i_mem_read/i_mem_write, i_signed, i_byte_en/i_halfword_en/i_word_en
//   i_addr (byte address), i_write_data, i_branch, i_zero, i_debug_addr
//   o_read_data (extended load), o_pc_src, o_misaligned, o_ready,
//   o_debug_data (word at i_debug_addr)
module mem_stage #(
  parameter int NB_DATA  = mem_stage_pkg::NB_DATA,
  parameter int NB_WADDR = mem_stage_pkg::NB_WADDR
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_pipeline_enable,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic                i_signed,
  input  logic                i_byte_en,
  input  logic                i_halfword_en,
  input  logic                i_word_en,
  input  logic [NB_DATA-1:0]  i_addr,
  input  logic [NB_DATA-1:0]  i_write_data,
  input  logic                i_branch,
  input  logic                i_zero,
  input  logic [NB_WADDR-1:0] i_debug_addr,
  output logic [NB_DATA-1:0]  o_read_data,
  output logic                o_pc_src,
  output logic                o_misaligned,
  output logic                o_ready,
  output logic [NB_DATA-1:0]  o_debug_data
);
  import mem_stage_pkg::*;

  localparam logic [NB_WADDR-1:0] LAST_WORD = '1;

  state_e              state_q, state_d;
  logic [NB_WADDR-1:0] clr_cnt_q, clr_cnt_d;

  size_e               size;
  logic [NB_WADDR-1:0] word_addr;
  logic [1:0]          byte_off;
  logic                ready;

  logic                wr_en;
  logic [NB_LANES-1:0] wr_be;
  logic [NB_WADDR-1:0] wr_addr;
  logic [NB_DATA-1:0]  wr_data;
  logic [NB_LANES-1:0] store_be;
  logic [NB_DATA-1:0]  store_data;
  logic [NB_DATA-1:0]  rd_word;
  logic [NB_DATA-1:0]  dbg_word;
  logic [NB_DATA-1:0]  load_ext;
  logic [NB_BYTE-1:0]  load_byte;
  logic [15:0]         load_half;

  // Address bits above the word index are ignored so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_addr[NB_DATA-1:NB_WADDR+2];

  assign size      = decode_size(i_byte_en, i_halfword_en, i_word_en);
  assign word_addr = i_addr[NB_WADDR+1:2];
  assign byte_off  = i_addr[1:0];
  assign ready     = (state_q == ST_IDLE);
  assign o_ready   = ready;
  assign o_pc_src  = i_branch & i_zero;

  assign o_misaligned = (i_mem_read | i_mem_write) &&
                        (((size == SZ_HALF) && byte_off[0]) ||
                         ((size == SZ_WORD) && (byte_off != 2'b00)));

  // ---------------- control FSM ----------------
  always_ff @(posedge i_clock) begin
    state_q   <= state_d;
    clr_cnt_q <= clr_cnt_d;
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (i_reset) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_WORD) state_d = ST_IDLE;
        end
        ST_IDLE: ;
      endcase
    end
  end

  // ---------------- store lane steering ----------------
  // Data is replicated across lanes; the lane enables pick the target.
  always_comb begin
    store_be   = LANES_NONE;
    store_data = i_write_data;
    case (size)
      SZ_BYTE: begin
        store_be   = LANES_BYTE0 << byte_off;
        store_data = {NB_LANES{i_write_data[7:0]}};
      end
      SZ_HALF: begin
        store_be   = byte_off[1] ? LANES_HI_HALF : LANES_LO_HALF;
        store_data = {(NB_LANES/2){i_write_data[15:0]}};
      end
      SZ_WORD: store_be = LANES_ALL;
      default: store_be = LANES_NONE;
    endcase
  end

  // Write-port mux: the clear sweep owns the port until IDLE; nothing is
  // written in a reset cycle (drops stores and restarts the sweep cleanly).
  always_comb begin
    wr_en   = 1'b0;
    wr_be   = LANES_NONE;
    wr_addr = word_addr;
    wr_data = store_data;
    if (!i_reset) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_be   = LANES_ALL;
        wr_addr = clr_cnt_q;
        wr_data = '0;
      end else if (i_mem_write && i_pipeline_enable && !o_misaligned &&
                   (size != SZ_NONE)) begin
        wr_en = 1'b1;
        wr_be = store_be;
      end
    end
  end

  data_memory #(
    .NB_DATA  (NB_DATA),
    .NB_WADDR (NB_WADDR)
  ) u_data_memory (
    .i_clock    (i_clock),
    .i_wr_en    (wr_en),
    .i_wr_be    (wr_be),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rd_addr  (word_addr),
    .o_rd_data  (rd_word),
    .i_dbg_addr (i_debug_addr),
    .o_dbg_data (dbg_word)
  );

  // ---------------- load extraction ----------------
  always_comb begin
    case (byte_off)
      2'd0:    load_byte = rd_word[7:0];
      2'd1:    load_byte = rd_word[15:8];
      2'd2:    load_byte = rd_word[23:16];
      default: load_byte = rd_word[31:24];
    endcase
    load_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    load_ext = '0;
    case (size)
      SZ_BYTE: load_ext = {{(NB_DATA-8){i_signed & load_byte[7]}}, load_byte};
      SZ_HALF: load_ext = {{(NB_DATA-16){i_signed & load_half[15]}}, load_half};
      SZ_WORD: load_ext = rd_word;
      default: load_ext = '0;
    endcase
  end

  // Read data shows pre-store contents when read and write coincide,
  // because the write only lands at the clock edge.
  assign o_read_data  = (i_mem_read && !o_misaligned && ready) ? load_ext : '0;
  assign o_debug_data = ready ? dbg_word : '0;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_pipeline_enable = 1'b1;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic        i_signed = 1'b0;
  logic        i_byte_en = 1'b0;
  logic        i_halfword_en = 1'b0;
  logic        i_word_en = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_write_data = '0;
  logic        i_branch = 1'b0;
  logic        i_zero = 1'b0;
  logic [7:0]  i_debug_addr = '0;
  logic [31:0] o_read_data;
  logic        o_pc_src;
  logic        o_misaligned;
  logic        o_ready;
  logic [31:0] o_debug_data;

  int errors = 0;
  int checks = 0;
  int cycles;

  localparam int SZ_B = 1, SZ_H = 2, SZ_W = 3;

  mem_stage dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_pipeline_enable (i_pipeline_enable),
    .i_mem_read        (i_mem_read),
    .i_mem_write       (i_mem_write),
    .i_signed          (i_signed),
    .i_byte_en         (i_byte_en),
    .i_halfword_en     (i_halfword_en),
    .i_word_en         (i_word_en),
    .i_addr            (i_addr),
    .i_write_data      (i_write_data),
    .i_branch          (i_branch),
    .i_zero            (i_zero),
    .i_debug_addr      (i_debug_addr),
    .o_read_data       (o_read_data),
    .o_pc_src          (o_pc_src),
    .o_misaligned      (o_misaligned),
    .o_ready           (o_ready),
    .o_debug_data      (o_debug_data)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-22s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic set_access(input logic rd, input logic wr, input int sz,
                            input logic sgn, input logic [31:0] addr,
                            input logic [31:0] data);
    i_mem_read    = rd;
    i_mem_write   = wr;
    i_byte_en     = (sz == SZ_B);
    i_halfword_en = (sz == SZ_H);
    i_word_en     = (sz == SZ_W);
    i_signed      = sgn;
    i_addr        = addr;
    i_write_data  = data;
  endtask

  task automatic clear_access();
    set_access(1'b0, 1'b0, 0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input int sz);
    @(negedge i_clock);
    set_access(1'b0, 1'b1, sz, 1'b0, addr, data);
    @(posedge i_clock);
    #1 clear_access();
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr, input int sz,
                            input logic sgn, input logic [31:0] exp);
    @(negedge i_clock);
    set_access(1'b1, 1'b0, sz, sgn, addr, 32'h0);
    #1 check(tag, o_read_data, exp);
    clear_access();
  endtask

  task automatic dbg_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    @(negedge i_clock);
    i_debug_addr = addr;
    #1 check(tag, o_debug_data, exp);
  endtask

  // Pulse reset for one cycle and count edges (reset edge included) until ready.
  task automatic reset_and_wait(input string tag);
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock);
    cycles = 1;
    #1 i_reset = 1'b0;
    while (!o_ready && cycles < 1000) begin
      @(posedge i_clock);
      cycles++;
      #1;
    end
    check(tag, cycles, 32'd257);
  endtask

  initial begin
    // ---- first reset, checks inside the reset/clear window ----
    @(negedge i_clock);
    i_reset = 1'b1;
    set_access(1'b1, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    i_branch = 1'b1;
    i_zero   = 1'b1;
    @(posedge i_clock);
    #1 i_reset = 1'b0;
    cycles = 1;
    check("rst_ready", {31'b0, o_ready}, 32'd0);
    check("rst_read_data", o_read_data, 32'h0);
    check("rst_debug", o_debug_data, 32'h0);
    check("rst_pc_src", {31'b0, o_pc_src}, 32'd1);
    set_access(1'b1, 1'b0, SZ_H, 1'b0, 32'h1, 32'h0);
    #1 check("clr_misaligned", {31'b0, o_misaligned}, 32'd1);
    clear_access();
    i_branch = 1'b0;
    while (!o_ready && cycles < 1000) begin
      @(posedge i_clock);
      cycles++;
      #1;
    end
    check("ready_latency", cycles, 32'd257);
    dbg_check("clr_dbg_0", 8'd0, 32'h0);
    dbg_check("clr_dbg_128", 8'd128, 32'h0);
    dbg_check("clr_dbg_255", 8'd255, 32'h0);

    // ---- word store then lane loads ----
    store(32'h10, 32'h8001_7F80, SZ_W);
    load_check("lb_10", 32'h10, SZ_B, 1'b1, 32'hFFFF_FF80);
    load_check("lb_11", 32'h11, SZ_B, 1'b1, 32'h0000_007F);
    load_check("lb_12", 32'h12, SZ_B, 1'b1, 32'h0000_0001);
    load_check("lb_13", 32'h13, SZ_B, 1'b1, 32'hFFFF_FF80);
    load_check("lhu_12", 32'h12, SZ_H, 1'b0, 32'h0000_8001);
    load_check("lh_12", 32'h12, SZ_H, 1'b1, 32'hFFFF_8001);
    load_check("lbu_10", 32'h10, SZ_B, 1'b0, 32'h0000_0080);
    load_check("lw_10", 32'h10, SZ_W, 1'b0, 32'h8001_7F80);
    dbg_check("dbg_word4", 8'd4, 32'h8001_7F80);

    // ---- partial stores preserve other lanes ----
    store(32'h20, 32'h1122_3344, SZ_W);
    store(32'h21, 32'hFFFF_FFAB, SZ_B);
    load_check("sb_21", 32'h20, SZ_W, 1'b0, 32'h1122_AB44);
    store(32'h22, 32'h0000_BEEF, SZ_H);
    load_check("sh_22", 32'h20, SZ_W, 1'b0, 32'hBEEF_AB44);

    // ---- misaligned word store is dropped ----
    @(negedge i_clock);
    set_access(1'b0, 1'b1, SZ_W, 1'b0, 32'h22, 32'h5555_5555);
    #1 check("mis_store_flag", {31'b0, o_misaligned}, 32'd1);
    @(posedge i_clock);
    #1 clear_access();
    dbg_check("mis_store_nochg", 8'd8, 32'hBEEF_AB44);
    load_check("mis_load_zero", 32'h22, SZ_W, 1'b0, 32'h0);
    @(negedge i_clock);
    set_access(1'b0, 1'b0, SZ_W, 1'b0, 32'h22, 32'h0);
    #1 check("mis_no_access", {31'b0, o_misaligned}, 32'd0);
    set_access(1'b1, 1'b0, SZ_H, 1'b0, 32'h23, 32'h0);
    #1 check("mis_half_23", {31'b0, o_misaligned}, 32'd1);
    clear_access();

    // ---- frozen pipeline blocks stores, debug port still live ----
    i_pipeline_enable = 1'b0;
    store(32'h30, 32'h1234_5678, SZ_W);
    dbg_check("frozen_nochg", 8'd12, 32'h0);
    dbg_check("frozen_dbg", 8'd4, 32'h8001_7F80);
    i_pipeline_enable = 1'b1;

    // ---- branch decision ----
    @(negedge i_clock);
    i_branch = 1'b1; i_zero = 1'b1;
    #1 check("pc_src_11", {31'b0, o_pc_src}, 32'd1);
    i_zero = 1'b0;
    #1 check("pc_src_10", {31'b0, o_pc_src}, 32'd0);
    i_branch = 1'b0;

    // ---- address wrap, read+write together, no size enable ----
    store(32'h440, 32'hCAFE_F00D, SZ_W);
    dbg_check("wrap_dbg16", 8'd16, 32'hCAFE_F00D);
    @(negedge i_clock);
    set_access(1'b1, 1'b1, SZ_W, 1'b0, 32'h40, 32'h0BAD_C0DE);
    #1 check("rw_pre_store", o_read_data, 32'hCAFE_F00D);
    @(posedge i_clock);
    #1 clear_access();
    dbg_check("rw_post_store", 8'd16, 32'h0BAD_C0DE);
    load_check("no_size_zero", 32'h40, 0, 1'b0, 32'h0);

    // ---- reset in the middle of the clear sweep ----
    @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock);
    #1 i_reset = 1'b0;
    repeat (100) @(posedge i_clock);
    #1 check("midclr_ready", {31'b0, o_ready}, 32'd0);
    dbg_check("midclr_dbg", 8'd16, 32'h0);
    reset_and_wait("re_reset_latency");
    dbg_check("reclr_dbg4", 8'd4, 32'h0);
    dbg_check("reclr_dbg16", 8'd16, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
